writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter_if.sv | 19 +
 rtl/writeback_arbiter.sv | 58 +++++
 tb/tb_writeback_arbiter.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: ALU result, load issue/response and register file write bundle
interface writeback_arbiter_if;
   logic        alu_valid, alu_ready;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_issue;
   logic [4:0]  ld_issue_rd;
   logic        ld_valid, ld_ready;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        rf_we;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_rd_data;
   logic [31:0] busy_mask;
   modport master(output alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
                  input alu_ready, ld_ready, rf_we, rf_rd_addr, rf_rd_data, busy_mask);
   modport slave(input alu_valid, alu_rd, alu_data, ld_issue, ld_issue_rd, ld_valid, ld_rd, ld_data,
                 output alu_ready, ld_ready, rf_we, rf_rd_addr, rf_rd_data, busy_mask);
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: shares one register file write port between ALU results and a 2-deep load FIFO
module writeback_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input logic clk,
   input logic rst_n,
   writeback_arbiter_if.slave bus
);
   logic [1:0]  count, wpos;
   logic [36:0] e0, e1;
   logic [3:0]  starve;
   logic        alu_fire, push, pop, we_q;
   logic [4:0]  head_rd, addr_q;
   logic [31:0] data_q, busy_q, set_m, clr_m;
   assign bus.ld_ready   = count != 2'd2;
   assign bus.alu_ready  = starve != 4'(STARVE_LIMIT);
   assign bus.rf_we      = we_q;
   assign bus.rf_rd_addr = addr_q;
   assign bus.rf_rd_data = data_q;
   assign bus.busy_mask  = busy_q;
   always_comb begin
      alu_fire = bus.alu_valid && bus.alu_ready;
      push     = bus.ld_valid && bus.ld_ready;
      pop      = !alu_fire && count != 2'd0;
      wpos     = count - {1'b0, pop};
      head_rd  = e0[36:32];
      set_m    = (bus.ld_issue && bus.ld_issue_rd != 5'd0) ? 32'd1 << bus.ld_issue_rd : 32'd0;
      clr_m    = (pop && head_rd != 5'd0) ? 32'd1 << head_rd : 32'd0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count  <= '0;
         e0     <= '0;
         e1     <= '0;
         starve <= '0;
         we_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         busy_q <= '0;
      end else begin
         count <= count + {1'b0, push} - {1'b0, pop};
         if (pop) e0 <= e1;
         // a push landing on slot 0 overrides the shift when the FIFO drains and refills together
         if (push && wpos == 2'd0) e0 <= {bus.ld_rd, bus.ld_data};
         if (push && wpos != 2'd0) e1 <= {bus.ld_rd, bus.ld_data};
         starve <= (pop || count == 2'd0) ? 4'd0 : starve + 4'd1;
         we_q   <= alu_fire ? bus.alu_rd != 5'd0 : pop && head_rd != 5'd0;
         if (alu_fire && bus.alu_rd != 5'd0) begin
            addr_q <= bus.alu_rd;
            data_q <= bus.alu_data;
         end else if (pop && head_rd != 5'd0) begin
            addr_q <= head_rd;
            data_q <= e0[31:0];
         end
         busy_q <= (busy_q & ~clr_m) | set_m;
      end
   end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: vector table, corner sequences and random traffic against a queue model
module tb_writeback_arbiter;
   localparam int LIM = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   writeback_arbiter_if bus();
   writeback_arbiter #(.STARVE_LIMIT(LIM)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   typedef struct packed {logic [4:0] rd; logic [31:0] data;} ent_t;
   typedef struct {
      logic av; logic [4:0] ard; logic [31:0] ad;
      logic li; logic [4:0] lir;
      logic lv; logic [4:0] lrd; logic [31:0] ld;
      logic we; logic [4:0] a; logic [31:0] d; logic [31:0] bm;
   } vec_t;

   int tests = 0, fails = 0;
   ent_t q[$];
   int starve;
   logic [31:0] m_busy, m_data;
   logic [4:0] m_addr;
   logic m_we;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
      bus.ld_issue = 1'b0; bus.ld_issue_rd = '0;
      bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
   endtask

   // one clock: predict from the current inputs, advance, compare registered outputs
   task automatic step();
      bit ar, lr, af, ne, pp;
      ent_t e;
      ar = starve != LIM;
      lr = q.size() < 2;
      if (rst_n) begin
         chk("alu_ready", 32'(bus.alu_ready), 32'(ar));
         chk("ld_ready", 32'(bus.ld_ready), 32'(lr));
      end
      if (!rst_n) begin
         q.delete(); starve = 0; m_busy = '0; m_we = 1'b0; m_addr = '0; m_data = '0;
      end else begin
         af = bus.alu_valid && ar;
         ne = q.size() != 0;
         pp = !af && ne;
         m_we = 1'b0;
         if (af) begin
            if (bus.alu_rd != 0) begin m_we = 1'b1; m_addr = bus.alu_rd; m_data = bus.alu_data; end
         end else if (pp) begin
            e = q.pop_front();
            if (e.rd != 0) begin m_we = 1'b1; m_addr = e.rd; m_data = e.data; m_busy[e.rd] = 1'b0; end
         end
         if (bus.ld_valid && lr) q.push_back({bus.ld_rd, bus.ld_data});
         if (pp || !ne) starve = 0;
         else if (af) starve++;
         if (bus.ld_issue && bus.ld_issue_rd != 0) m_busy[bus.ld_issue_rd] = 1'b1;
      end
      @(posedge clk);
      #1;
      chk("rf_we", 32'(bus.rf_we), 32'(m_we));
      chk("rf_rd_addr", 32'(bus.rf_rd_addr), 32'(m_addr));
      chk("rf_rd_data", bus.rf_rd_data, m_data);
      chk("busy_mask", bus.busy_mask, m_busy);
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      vec_t tbl[13];
      ent_t got[$];
      int acc, n;
      tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hDEADBEEF, 32'h0};
      tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd5, 32'hDEADBEEF, 32'h0};
      tbl[2]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 1'b0, 5'd0, 32'h0,  1'b0, 5'd5, 32'hDEADBEEF, 32'h80};
      tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd5, 32'hDEADBEEF, 32'h80};
      tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd5, 32'hDEADBEEF, 32'h80};
      tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd5, 32'hDEADBEEF, 32'h80};
      tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd7, 32'h1234, 32'h0};
      tbl[7]  = '{1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 32'h1234, 32'h0};
      tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b1, 5'd0, 32'h99, 1'b0, 5'd7, 32'h1234, 32'h0};
      tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd7, 32'h1234, 32'h0};
      tbl[10] = '{1'b1, 5'd3, 32'h33,       1'b1, 5'd3, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h33, 32'h8};
      tbl[11] = '{1'b1, 5'd3, 32'h44,       1'b0, 5'd0, 1'b0, 5'd0, 32'h0,  1'b1, 5'd3, 32'h44, 32'h8};
      tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 1'b0, 5'd0, 32'h0,  1'b0, 5'd3, 32'h44, 32'h8};
      idle();
      rst_n = 1'b0;
      step();
      step();
      chk("reset_rf_we", 32'(bus.rf_we), 32'h0);
      chk("reset_addr", 32'(bus.rf_rd_addr), 32'h0);
      chk("reset_data", bus.rf_rd_data, 32'h0);
      chk("reset_busy", bus.busy_mask, 32'h0);
      chk("reset_alu_ready", 32'(bus.alu_ready), 32'h1);
      chk("reset_ld_ready", 32'(bus.ld_ready), 32'h1);
      rst_n = 1'b1;
      for (int i = 0; i < 13; i++) begin
         bus.alu_valid = tbl[i].av; bus.alu_rd = tbl[i].ard; bus.alu_data = tbl[i].ad;
         bus.ld_issue = tbl[i].li; bus.ld_issue_rd = tbl[i].lir;
         bus.ld_valid = tbl[i].lv; bus.ld_rd = tbl[i].lrd; bus.ld_data = tbl[i].ld;
         step();
         chk($sformatf("vec%0d_we", i), 32'(bus.rf_we), 32'(tbl[i].we));
         chk($sformatf("vec%0d_addr", i), 32'(bus.rf_rd_addr), 32'(tbl[i].a));
         chk($sformatf("vec%0d_data", i), bus.rf_rd_data, tbl[i].d);
         chk($sformatf("vec%0d_busy", i), bus.busy_mask, tbl[i].bm);
      end

      // backpressure: continuous ALU traffic, three loads offered back-to-back
      do_reset();
      acc = 0;
      for (int c = 0; c < 60 && got.size() < 3; c++) begin
         bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'(c);
         bus.ld_valid = acc < 3; bus.ld_rd = 5'(10 + acc); bus.ld_data = 32'(100 + acc);
         n = acc;
         if (bus.ld_valid && bus.ld_ready) acc++;
         step();
         if (n == 1 && acc == 2) chk("bp_ld_ready_full", 32'(bus.ld_ready), 32'h0);
         if (bus.rf_we && bus.rf_rd_addr >= 5'd10) got.push_back({bus.rf_rd_addr, bus.rf_rd_data});
      end
      chk("bp_writes", 32'(got.size()), 32'd3);
      for (int k = 0; k < 3 && k < got.size(); k++) begin
         chk($sformatf("bp_order%0d_addr", k), 32'(got[k].rd), 32'(10 + k));
         chk($sformatf("bp_order%0d_data", k), got[k].data, 32'(100 + k));
      end

      // starvation: one pending load held off by ALU until the limit trips
      do_reset();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h77;
      bus.ld_valid = 1'b1; bus.ld_rd = 5'd9; bus.ld_data = 32'hAB;
      step();
      bus.ld_valid = 1'b0;
      n = 0;
      for (int c = 0; c < 10 && bus.alu_ready; c++) begin
         n++;
         step();
      end
      chk("starve_ready_cycles", 32'(n), 32'(LIM));
      chk("starve_alu_held", 32'(bus.alu_ready), 32'h0);
      step();
      chk("starve_load_we", 32'(bus.rf_we), 32'h1);
      chk("starve_load_addr", 32'(bus.rf_rd_addr), 32'd9);
      chk("starve_load_data", bus.rf_rd_data, 32'hAB);
      chk("starve_alu_back", 32'(bus.alu_ready), 32'h1);

      // reset with a full FIFO and a busy bit pending
      do_reset();
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h1;
      bus.ld_issue = 1'b1; bus.ld_issue_rd = 5'd12;
      step();
      bus.ld_issue = 1'b0;
      bus.ld_valid = 1'b1; bus.ld_rd = 5'd13; bus.ld_data = 32'hC0;
      step();
      bus.ld_rd = 5'd14; bus.ld_data = 32'hC1;
      step();
      chk("rst_pre_full", 32'(bus.ld_ready), 32'h0);
      idle();
      rst_n = 1'b0;
      step();
      chk("rst_we", 32'(bus.rf_we), 32'h0);
      chk("rst_addr", 32'(bus.rf_rd_addr), 32'h0);
      chk("rst_data", bus.rf_rd_data, 32'h0);
      chk("rst_busy", bus.busy_mask, 32'h0);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("rst_no_write", 32'(bus.rf_we), 32'h0);
      end

      // random traffic with occasional reset
      for (int c = 0; c < 400; c++) begin
         rst_n = $urandom_range(0, 99) != 0;
         bus.alu_valid = $urandom_range(0, 3) != 0;
         bus.alu_rd = 5'($urandom_range(0, 7));
         bus.alu_data = $urandom;
         bus.ld_issue = $urandom_range(0, 2) == 0;
         bus.ld_issue_rd = 5'($urandom_range(0, 31));
         bus.ld_valid = $urandom_range(0, 1) != 0;
         bus.ld_rd = 5'($urandom_range(0, 31));
         bus.ld_data = $urandom;
         step();
      end
      rst_n = 1'b1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
